// File: rtl/fifo_flops_ext.sv
// Flop-based synchronous FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, error pulses and flush.
module fifo_flops_ext #(
  parameter int depth = 8,
  parameter int bits  = 16,
  parameter int fwft  = 0,
  parameter int af_th = depth - 2,
  parameter int ae_th = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [bits-1:0]              Din,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  output logic [bits-1:0]              Dout,
  output logic                         full,
  output logic                         pndng,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);

  if (depth < 2) begin : g_bad_depth
    $error("fifo_flops_ext: depth must be at least 2");
  end
  if (af_th < 1 || af_th > depth) begin : g_bad_af_th
    $error("fifo_flops_ext: af_th must lie in 1..depth");
  end
  if (ae_th < 0 || ae_th > depth - 1) begin : g_bad_ae_th
    $error("fifo_flops_ext: ae_th must lie in 0..depth-1");
  end

  logic [bits-1:0] mem_q [depth];
  logic [bits-1:0] mem_d [depth];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [bits-1:0] dout_q, dout_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            push_ok, pop_ok;

  // Flags decode only the registered count, so push/pop never reach them combinationally.
  assign full         = (count_q == CW'(depth));
  assign pndng        = (count_q != '0);
  assign almost_full  = (count_q >= CW'(af_th));
  assign almost_empty = (count_q <= CW'(ae_th));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign Dout         = (fwft != 0) ? mem_q[rd_ptr_q] : dout_q;

  always_comb begin
    push_ok     = push && (!full || pop) && !flush;
    pop_ok      = pop && pndng && !flush;
    overflow_d  = push && full && !pop && !flush;
    underflow_d = pop && !pndng && !flush;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = Din;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        dout_d   = mem_q[rd_ptr_q];
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Storage is never reset or flushed; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_flops_ext.sv
// Bench for fifo_flops_ext: a depth-8 standard-read instance driven from a vector
// table, and a depth-5 first-word-fall-through instance driven randomly.
module tb_fifo_flops_ext;

  typedef struct {
    logic        push;
    logic        pop;
    logic        flush;
    logic [15:0] din;
    int          expCount;
    logic        expOvf;
    logic        expUnf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] din0 = '0;
  logic        push0 = 1'b0, pop0 = 1'b0, flush0 = 1'b0;
  logic [15:0] dout0;
  logic        full0, pndng0, af0, ae0, ovf0, unf0;
  logic [3:0]  count0;

  logic [15:0] din1 = '0;
  logic        push1 = 1'b0, pop1 = 1'b0, flush1 = 1'b0;
  logic [15:0] dout1;
  logic        full1, pndng1, af1, ae1, ovf1, unf1;
  logic [2:0]  count1;

  int total = 0;
  int bad = 0;

  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [15:0] lastDout0 = '0;
  vec_t        vecs[$];

  fifo_flops_ext #(.depth(8), .bits(16), .fwft(0), .af_th(6), .ae_th(1)) dut0 (
    .clk(clk), .rst(rst), .Din(din0), .push(push0), .pop(pop0), .flush(flush0),
    .Dout(dout0), .full(full0), .pndng(pndng0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_flops_ext #(.depth(5), .bits(16), .fwft(1), .af_th(3), .ae_th(1)) dut1 (
    .clk(clk), .rst(rst), .Din(din1), .push(push1), .pop(pop1), .flush(flush1),
    .Dout(dout1), .full(full1), .pndng(pndng1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void add(logic p, logic q, logic f, logic [15:0] d,
                              int c, logic ov, logic un);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.din = d;
    v.expCount = c; v.expOvf = ov; v.expUnf = un;
    vecs.push_back(v);
  endfunction

  // Drives one cycle on the standard-read instance and updates the reference queue.
  task automatic applyStimulus(input vec_t v);
    logic fullM, pndM;
    fullM = (mq0.size() == 8);
    pndM  = (mq0.size() != 0);
    din0 = v.din; push0 = v.push; pop0 = v.pop; flush0 = v.flush;
    if (v.flush) begin
      mq0.delete();
      lastDout0 = '0;
    end else begin
      if (v.pop && pndM) lastDout0 = mq0.pop_front();
      if (v.push && (!fullM || v.pop)) mq0.push_back(v.din);
    end
    @(posedge clk);
    #1;
    push0 = 1'b0; pop0 = 1'b0; flush0 = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".count"}, 32'(count0), 32'(v.expCount));
    chk({tag, ".full"}, 32'(full0), 32'(v.expCount == 8));
    chk({tag, ".pndng"}, 32'(pndng0), 32'(v.expCount != 0));
    chk({tag, ".almost_full"}, 32'(af0), 32'(v.expCount >= 6));
    chk({tag, ".almost_empty"}, 32'(ae0), 32'(v.expCount <= 1));
    chk({tag, ".overflow"}, 32'(ovf0), 32'(v.expOvf));
    chk({tag, ".underflow"}, 32'(unf0), 32'(v.expUnf));
    chk({tag, ".Dout"}, 32'(dout0), 32'(lastDout0));
  endtask

  // One cycle on the fall-through instance, checked against its reference queue.
  task automatic applyStimulusFwft(input logic p, input logic q, input logic [15:0] d,
                                   input int idx);
    logic fullM, pndM, expOvf, expUnf;
    fullM  = (mq1.size() == 5);
    pndM   = (mq1.size() != 0);
    expOvf = p && fullM && !q;
    expUnf = q && !pndM;
    din1 = d; push1 = p; pop1 = q;
    if (q && pndM) void'(mq1.pop_front());
    if (p && (!fullM || q)) mq1.push_back(d);
    @(posedge clk);
    #1;
    push1 = 1'b0; pop1 = 1'b0;
    checkOutputFwft(expOvf, expUnf, idx);
  endtask

  task automatic checkOutputFwft(input logic expOvf, input logic expUnf, input int idx);
    string tag;
    int n;
    tag = $sformatf("fwft%0d", idx);
    n = mq1.size();
    chk({tag, ".count"}, 32'(count1), 32'(n));
    chk({tag, ".pndng"}, 32'(pndng1), 32'(n != 0));
    chk({tag, ".full"}, 32'(full1), 32'(n == 5));
    chk({tag, ".almost_full"}, 32'(af1), 32'(n >= 3));
    chk({tag, ".almost_empty"}, 32'(ae1), 32'(n <= 1));
    chk({tag, ".overflow"}, 32'(ovf1), 32'(expOvf));
    chk({tag, ".underflow"}, 32'(unf1), 32'(expUnf));
    if (n != 0) chk({tag, ".Dout"}, 32'(dout1), 32'(mq1[0]));
  endtask

  initial begin
    vec_t v;

    for (int i = 1; i <= 8; i++) add(1, 0, 0, 16'(i), i, 0, 0);
    add(1, 0, 0, 16'hBEEF, 8, 1, 0);
    add(0, 0, 0, 16'h0000, 8, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 16'h0000, 8 - i, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 1);
    add(0, 1, 0, 16'h0000, 0, 0, 1);
    add(1, 1, 0, 16'h1234, 1, 0, 1);
    add(0, 0, 0, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 16'h0011 + 16'(i), 2 + i, 0, 0);
    add(1, 1, 0, 16'hBEEF, 8, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 16'h0000, 8 - i, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 16'h0040 + 16'(i), i, 0, 0);
    add(1, 1, 1, 16'h0099, 0, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 1);
    add(1, 0, 0, 16'h0AAA, 1, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset.count", 32'(count0), 32'd0);
    chk("reset.full", 32'(full0), 32'd0);
    chk("reset.pndng", 32'(pndng0), 32'd0);
    chk("reset.almost_full", 32'(af0), 32'd0);
    chk("reset.almost_empty", 32'(ae0), 32'd1);
    chk("reset.overflow", 32'(ovf0), 32'd0);
    chk("reset.underflow", 32'(unf0), 32'd0);
    chk("reset.Dout", 32'(dout0), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    add(1, 0, 0, 16'h0021, 1, 0, 0);
    add(1, 0, 0, 16'h0022, 2, 0, 0);
    add(1, 0, 0, 16'h0023, 3, 0, 0);
    add(0, 1, 0, 16'h0000, 2, 0, 0);
    for (int i = vecs.size() - 4; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    #3;
    rst = 1'b0;
    #1;
    mq0.delete();
    lastDout0 = '0;
    chk("async_rst.count", 32'(count0), 32'd0);
    chk("async_rst.pndng", 32'(pndng0), 32'd0);
    chk("async_rst.full", 32'(full0), 32'd0);
    chk("async_rst.almost_empty", 32'(ae0), 32'd1);
    chk("async_rst.Dout", 32'(dout0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    add(1, 0, 0, 16'h5555, 1, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 0, 0);
    for (int i = vecs.size() - 2; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    mq1.delete();
    for (int i = 0; i < 5; i++) applyStimulusFwft(1'b1, 1'b0, 16'h00A0 + 16'(i), i);
    applyStimulusFwft(1'b1, 1'b0, 16'hDEAD, 5);
    for (int i = 0; i < 3; i++) applyStimulusFwft(1'b0, 1'b1, 16'h0000, 6 + i);
    for (int i = 0; i < 40; i++) begin
      logic p, q;
      p = ($urandom_range(0, 99) < 60);
      q = ($urandom_range(0, 99) < 50);
      applyStimulusFwft(p, q, 16'($urandom), 9 + i);
    end
    while (mq1.size() != 0) applyStimulusFwft(1'b0, 1'b1, 16'h0000, 100 + mq1.size());

    v = vecs[0];
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
